// File: rtl/cfg_pkg.sv
// Shared definitions for the configuration subsystem: word count, system address
// width and the APB front-end state encoding.
package cfg_pkg;

    localparam int unsigned CFG_WORDS = 64;
    localparam int unsigned CFG_AW    = 6;
    localparam int unsigned APB_AW    = 16;
    localparam int unsigned APB_DW    = 32;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR      = 3'd1,
        ST_RD_ADDR = 3'd2,
        ST_RD_DATA = 3'd3,
        ST_ERR     = 3'd4
    } cfg_state_e;

endpackage

// File: rtl/apb_cfg_slave.sv
// APB3 slave front-end for the configuration memory: decodes setup/access,
// range-checks and cfg_mode-gates writes, and adds one wait state for reads.
module apb_cfg_slave
    import cfg_pkg::*;
#(
    parameter int unsigned K = CFG_WORDS,
    parameter int unsigned D = CFG_AW
) (
    input  logic                pclk,
    input  logic                prstn,
    input  logic                psel,
    input  logic                penable,
    input  logic                pwrite,
    input  logic [APB_AW-1:0]   paddr,
    input  logic [APB_DW-1:0]   pwdata,
    input  logic                cfg_mode,
    output logic                pready,
    output logic [APB_DW-1:0]   prdata,
    output logic                pslverr,
    output logic [APB_AW-1:0]   mem_addr,
    output logic                mem_write,
    output logic [APB_DW-1:0]   mem_wdata,
    input  logic [APB_DW-1:0]   mem_rdata
);

    // Highest legal word count: K, but never beyond what the D-bit system side can reach.
    localparam int unsigned SPAN = (K < (32'd1 << D)) ? K : (32'd1 << D);

    cfg_state_e          state_q, state_d;
    logic [APB_AW-1:0]   mem_addr_q, mem_addr_d;
    logic [APB_DW-1:0]   mem_wdata_q, mem_wdata_d;
    logic                pready_q, pready_d;
    logic                pslverr_q, pslverr_d;
    logic                mem_write_q, mem_write_d;
    logic                rd_sel_q, rd_sel_d;
    logic                in_range_c;

    assign in_range_c = (32'(paddr) < SPAN);

    // Next state, address/data capture, and the registered response flags.
    always_comb begin
        state_d     = state_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        unique case (state_q)
            ST_IDLE: begin
                if (psel && !penable) begin
                    mem_addr_d  = paddr;
                    mem_wdata_d = pwdata;
                    if (!in_range_c)            state_d = ST_ERR;
                    else if (pwrite && !cfg_mode) state_d = ST_ERR;
                    else if (pwrite)            state_d = ST_WR;
                    else                        state_d = ST_RD_ADDR;
                end
            end
            ST_WR:      state_d = ST_IDLE;
            // A master that drops psel here aborts; RD_DATA is never entered.
            ST_RD_ADDR: state_d = psel ? ST_RD_DATA : ST_IDLE;
            ST_RD_DATA: state_d = ST_IDLE;
            ST_ERR:     state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase

        pready_d    = (state_d == ST_WR) || (state_d == ST_RD_DATA) || (state_d == ST_ERR);
        pslverr_d   = (state_d == ST_ERR);
        mem_write_d = (state_d == ST_WR);
        rd_sel_d    = (state_d == ST_RD_DATA);
    end

    always_ff @(posedge pclk or negedge prstn) begin
        if (!prstn) begin
            state_q     <= ST_IDLE;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            pready_q    <= 1'b0;
            pslverr_q   <= 1'b0;
            mem_write_q <= 1'b0;
            rd_sel_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            pready_q    <= pready_d;
            pslverr_q   <= pslverr_d;
            mem_write_q <= mem_write_d;
            rd_sel_q    <= rd_sel_d;
        end
    end

    // Memory read data is already registered, so it passes straight through.
    assign prdata    = rd_sel_q ? mem_rdata : '0;
    assign pready    = pready_q;
    assign pslverr   = pslverr_q;
    assign mem_write = mem_write_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_apb_cfg_slave.sv
// Directed bench for apb_cfg_slave with a registered-read memory model attached.
module tb_apb_cfg_slave;
    import cfg_pkg::*;

    logic        pclk = 1'b0;
    logic        prstn = 1'b1;
    logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0, cfg_mode = 1'b1;
    logic [15:0] paddr = '0;
    logic [31:0] pwdata = '0;
    logic        pready, pslverr, mem_write;
    logic [31:0] prdata, mem_wdata;
    logic [15:0] mem_addr;
    logic [31:0] mem_rdata = '0;
    logic [31:0] mem [64];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    apb_cfg_slave #(.K(64), .D(6)) dut (
        .pclk(pclk), .prstn(prstn), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .cfg_mode(cfg_mode), .pready(pready),
        .prdata(prdata), .pslverr(pslverr), .mem_addr(mem_addr), .mem_write(mem_write),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 pclk = ~pclk;

    // Configuration memory model: synchronous write, registered read.
    always @(posedge pclk) begin
        cyc <= cyc + 1;
        if (mem_write && mem_addr < 16'd64) mem[mem_addr[5:0]] <= mem_wdata;
        mem_rdata <= (mem_addr < 16'd64) ? mem[mem_addr[5:0]] : 32'h0;
    end

    task automatic step();
        @(posedge pclk); #1;
    endtask

    task automatic idle_bus();
        psel = 1'b0; penable = 1'b0;
    endtask

    // Drive a setup phase, cross the setup edge, and raise penable for the access phase.
    task automatic apb_setup(input logic w, input logic [15:0] a, input logic [31:0] d);
        psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = d;
        step();
        penable = 1'b1;
    endtask

    task automatic test_reset();
        #2 prstn = 1'b0;
        #1;
        n_tests++;
        if ({pready, pslverr, mem_write, prdata, mem_addr, mem_wdata} !== 83'd0) begin
            n_fail++;
            $display("FAIL reset_outputs act=%h exp=0", {pready, pslverr, mem_write, prdata, mem_addr, mem_wdata});
        end
        step(); step();
        @(negedge pclk) prstn = 1'b1;
        step();
    endtask

    task automatic test_write();
        cfg_mode = 1'b1;
        apb_setup(1'b1, 16'd5, 32'hDEADBEEF);
        cfg_mode = 1'b0;  // change after the setup edge must not matter
        n_tests++;
        if ({pready, pslverr, mem_write} !== 3'b101) begin
            n_fail++; $display("FAIL wr_flags act=%b exp=101", {pready, pslverr, mem_write});
        end
        n_tests++;
        if (mem_addr !== 16'd5 || mem_wdata !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL wr_bus act=%h/%h exp=0005/deadbeef", mem_addr, mem_wdata);
        end
        step(); idle_bus(); cfg_mode = 1'b1;
        n_tests++;
        if ({pready, pslverr, mem_write} !== 3'b000) begin
            n_fail++; $display("FAIL wr_done_flags act=%b exp=000", {pready, pslverr, mem_write});
        end
        n_tests++;
        if (mem[5] !== 32'hDEADBEEF || mem_addr !== 16'd5) begin
            n_fail++; $display("FAIL wr_commit act=%h addr=%h exp=deadbeef addr=0005", mem[5], mem_addr);
        end
    endtask

    task automatic test_read();
        apb_setup(1'b0, 16'd5, 32'h0);
        n_tests++;
        if ({pready, pslverr, mem_write} !== 3'b000 || prdata !== 32'h0) begin
            n_fail++; $display("FAIL rd_wait act=%b/%h exp=000/0", {pready, pslverr, mem_write}, prdata);
        end
        step();
        n_tests++;
        if ({pready, pslverr, mem_write} !== 3'b100 || prdata !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL rd_data act=%b/%h exp=100/deadbeef", {pready, pslverr, mem_write}, prdata);
        end
        step(); idle_bus();
        n_tests++;
        if (pready !== 1'b0 || prdata !== 32'h0) begin
            n_fail++; $display("FAIL rd_done act=%b/%h exp=0/0", pready, prdata);
        end
    endtask

    task automatic test_errors();
        apb_setup(1'b1, 16'd64, 32'hCAFEF00D);
        n_tests++;
        if ({pready, pslverr, mem_write} !== 3'b110 || prdata !== 32'h0) begin
            n_fail++; $display("FAIL err_range act=%b/%h exp=110/0", {pready, pslverr, mem_write}, prdata);
        end
        step(); idle_bus();
        cfg_mode = 1'b0;
        apb_setup(1'b1, 16'd3, 32'h12345678);
        cfg_mode = 1'b1;
        n_tests++;
        if ({pready, pslverr, mem_write} !== 3'b110) begin
            n_fail++; $display("FAIL err_cfgmode act=%b exp=110", {pready, pslverr, mem_write});
        end
        step(); idle_bus();
        n_tests++;
        if (mem[3] !== 32'h0 || mem[0] !== 32'h0 || pslverr !== 1'b0) begin
            n_fail++; $display("FAIL err_nowrite act=%h/%h/%b exp=0/0/0", mem[3], mem[0], pslverr);
        end
        apb_setup(1'b0, 16'hFFFF, 32'h0);
        n_tests++;
        if ({pready, pslverr, mem_write} !== 3'b110) begin
            n_fail++; $display("FAIL err_rd_ffff act=%b exp=110", {pready, pslverr, mem_write});
        end
        step(); idle_bus();
        apb_setup(1'b1, 16'd63, 32'h0000A5A5);
        n_tests++;
        if ({pready, pslverr, mem_write} !== 3'b101) begin
            n_fail++; $display("FAIL wr_top_word act=%b exp=101", {pready, pslverr, mem_write});
        end
        step(); idle_bus();
        n_tests++;
        if (mem[63] !== 32'h0000A5A5) begin
            n_fail++; $display("FAIL wr_top_commit act=%h exp=0000a5a5", mem[63]);
        end
    endtask

    task automatic test_back_to_back();
        int c_wr, c_rd, c_err;
        apb_setup(1'b1, 16'd2, 32'h11);
        c_wr = cyc;
        n_tests++;
        if ({pready, pslverr, mem_write} !== 3'b101) begin
            n_fail++; $display("FAIL b2b_wr act=%b exp=101", {pready, pslverr, mem_write});
        end
        step();
        apb_setup(1'b0, 16'd2, 32'h0);
        step();
        c_rd = cyc;
        n_tests++;
        if ({pready, pslverr} !== 2'b10 || prdata !== 32'h11) begin
            n_fail++; $display("FAIL b2b_rd act=%b/%h exp=10/00000011", {pready, pslverr}, prdata);
        end
        step();
        apb_setup(1'b0, 16'd70, 32'h0);
        c_err = cyc;
        n_tests++;
        if ({pready, pslverr, mem_write} !== 3'b110) begin
            n_fail++; $display("FAIL b2b_err act=%b exp=110", {pready, pslverr, mem_write});
        end
        n_tests++;
        if (c_rd - c_wr !== 3 || c_err - c_rd !== 2) begin
            n_fail++; $display("FAIL b2b_timing act=%0d,%0d exp=3,2", c_rd - c_wr, c_err - c_rd);
        end
        step(); idle_bus();
    endtask

    task automatic test_reset_abort();
        apb_setup(1'b1, 16'd9, 32'h99);
        prstn = 1'b0;
        #1;
        n_tests++;
        if ({pready, pslverr, mem_write, prdata, mem_addr, mem_wdata} !== 83'd0) begin
            n_fail++; $display("FAIL rst_in_wr act=%h exp=0", {pready, pslverr, mem_write, prdata, mem_addr, mem_wdata});
        end
        idle_bus();
        @(negedge pclk) prstn = 1'b1;
        step();
        n_tests++;
        if (mem[9] !== 32'h0) begin
            n_fail++; $display("FAIL rst_cancel_wr act=%h exp=0", mem[9]);
        end
        apb_setup(1'b0, 16'd5, 32'h0);
        idle_bus();
        for (int i = 0; i < 2; i++) begin
            step();
            n_tests++;
            if ({pready, pslverr} !== 2'b00 || prdata !== 32'h0) begin
                n_fail++; $display("FAIL abort_rd_%0d act=%b/%h exp=00/0", i, {pready, pslverr}, prdata);
            end
        end
        apb_setup(1'b0, 16'd63, 32'h0);
        step();
        n_tests++;
        if ({pready, pslverr} !== 2'b10 || prdata !== 32'h0000A5A5) begin
            n_fail++; $display("FAIL after_abort act=%b/%h exp=10/0000a5a5", {pready, pslverr}, prdata);
        end
        step(); idle_bus();
    endtask

    task automatic test_stray_enable();
        psel = 1'b0; penable = 1'b1; pwrite = 1'b1; paddr = 16'd7; pwdata = 32'h77;
        for (int i = 0; i < 2; i++) begin
            step();
            n_tests++;
            if ({pready, pslverr, mem_write} !== 3'b000) begin
                n_fail++; $display("FAIL stray_en_%0d act=%b exp=000", i, {pready, pslverr, mem_write});
            end
        end
        psel = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_tests++;
            if ({pready, pslverr, mem_write} !== 3'b000) begin
                n_fail++; $display("FAIL nosetup_%0d act=%b exp=000", i, {pready, pslverr, mem_write});
            end
        end
        idle_bus(); step();
        n_tests++;
        if (mem[7] !== 32'h0 || mem_addr === 16'd7) begin
            n_fail++; $display("FAIL nosetup_nowrite act=%h addr=%h exp=0 addr!=0007", mem[7], mem_addr);
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        test_reset();
        test_write();
        test_read();
        test_errors();
        test_back_to_back();
        test_reset_abort();
        test_stray_enable();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
